// File: rtl/ahb_dm_bridge_if.sv
// AHB-Lite slave-side bus bundle for the data-memory backdoor bridge.
interface ahb_dm_bridge_if #(
  parameter int DATA_W = 32
);
  logic              hsel;
  logic [31:0]       haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_dm_bridge.sv
// AHB-Lite slave driving the MEM-stage data SRAM backdoor port.
// Writes own the port in their data phase; a colliding read stalls once.
module ahb_dm_bridge #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 2048
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              dm_access_en,
  ahb_dm_bridge_if.slave    bus,
  output logic [ADDR_W-1:0] ahb_dm_addr,
  output logic [DATA_W-1:0] ahb_dm_din,
  output logic              ahb_dm_wen,
  input  logic [DATA_W-1:0] ahb_dm_dout
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    RSTALL,
    ERR1,
    ERR2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] wr_idx_nxt;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] rd_idx_nxt;
  logic [DATA_W-1:0] rdata_q;
  logic [29:0]       word;
  logic [ADDR_W-1:0] idx;
  logic              ready;
  logic              accept;
  logic              legal;

  assign word  = bus.haddr[31:2];
  assign idx   = bus.haddr[ADDR_W+1:2];
  assign ready = (state != RSTALL) && (state != ERR1);

  // Gating with rstn keeps the address passthrough quiet during reset
  assign accept = rstn & bus.hsel & bus.htrans[1]
                & bus.hready & ready;

  assign legal = dm_access_en
              && (bus.hsize == 3'b010)
              && (bus.haddr[1:0] == 2'b00)
              && (word < 30'(MEM_WORDS));

  assign bus.hreadyout = ready;

  always_comb begin
    state_nxt   = state;
    wr_idx_nxt  = wr_idx;
    rd_idx_nxt  = rd_idx;
    ahb_dm_addr = '0;
    ahb_dm_din  = '0;
    ahb_dm_wen  = 1'b0;
    bus.hresp   = 1'b0;
    bus.hrdata  = rdata_q;
    unique case (state)
      RSTALL: begin
        ahb_dm_addr = rd_idx;
        state_nxt   = READ;
      end
      ERR1: begin
        bus.hresp = 1'b1;
        state_nxt = ERR2;
      end
      default: begin
        if (state == READ) bus.hrdata = ahb_dm_dout;
        if (state == ERR2) bus.hresp = 1'b1;
        if (state == WRITE) begin
          ahb_dm_addr = wr_idx;
          ahb_dm_din  = bus.hwdata;
          ahb_dm_wen  = 1'b1;
        end
        state_nxt = IDLE;
        if (accept) begin
          if (!legal) begin
            state_nxt = ERR1;
          end else if (bus.hwrite) begin
            state_nxt  = WRITE;
            wr_idx_nxt = idx;
          end else if (state == WRITE) begin
            state_nxt  = RSTALL;
            rd_idx_nxt = idx;
          end else begin
            state_nxt   = READ;
            ahb_dm_addr = idx;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      wr_idx  <= '0;
      rd_idx  <= '0;
      rdata_q <= '0;
    end else begin
      state  <= state_nxt;
      wr_idx <= wr_idx_nxt;
      rd_idx <= rd_idx_nxt;
      if (state == READ) rdata_q <= ahb_dm_dout;
    end
  end

endmodule

// File: doc/ahb_dm_bridge.md
Name: ahb_dm_bridge

Overview:
- AHB-Lite slave that drives the data-memory backdoor port of the MEM stage (ahb_dm_addr/ahb_dm_din/ahb_dm_wen/ahb_dm_dout).
- Host uses it to preload and dump data SRAM while the core is held in reset.
- Converts pipelined AHB address/data phases into single-port synchronous SRAM accesses (1-cycle read latency).
- Resolves write-then-read port conflicts with wait states and returns two-cycle ERROR responses for illegal transfers.

Parameters:
- ADDR_W, 11, SRAM word-address width (matches ahb_dm_addr).
- DATA_W, 32, data width.
- MEM_WORDS, 2048, implemented depth; word index >= MEM_WORDS is illegal.

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous active-low reset.
- dm_access_en  input  1  high only while the core is held in reset, i.e. while the backdoor owns the SRAM.
- hsel  input  1  AHB slave select.
- haddr  input  32  byte address; word index = haddr[ADDR_W+1:2].
- htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hwrite  input  1  1 = write.
- hsize  input  3  must be 3'b010 (word).
- hwdata  input  DATA_W  write data, valid in the data phase.
- hready  input  1  bus-level HREADY.
- hreadyout  output  1  slave ready.
- hresp  output  1  0 OKAY, 1 ERROR.
- hrdata  output  DATA_W  read data.
- ahb_dm_addr  output  ADDR_W  SRAM word address.
- ahb_dm_din  output  DATA_W  SRAM write data.
- ahb_dm_wen  output  1  SRAM write enable.
- ahb_dm_dout  input  DATA_W  SRAM read data, valid the cycle after the address is presented with wen=0.

Behaviour:
- Reset (rstn low, async): state=IDLE, hreadyout=1, hresp=0, hrdata=0, ahb_dm_wen=0, ahb_dm_addr=0, ahb_dm_din=0, all latched phase registers cleared. Reset asserted mid-transfer abandons the transfer; any SRAM write not yet issued is lost.
- Transfer accepted when hsel & htrans[1] & hready. IDLE and BUSY transfers get a zero-wait OKAY response.
- Legal transfer: dm_access_en=1, hsize=010, haddr[1:0]=00, word index < MEM_WORDS. Anything else is illegal.
- Illegal transfer: no SRAM access. Data phase is ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1), then back to IDLE.
- Read, no conflict: in the address phase, ahb_dm_addr=haddr word index combinationally with wen=0. Data phase (state READ) has hreadyout=1 and hrdata=ahb_dm_dout. Zero wait states.
- Write: the address phase latches the word index. In the data phase (state WRITE), drive ahb_dm_addr=latched index, ahb_dm_din=hwdata, ahb_dm_wen=1 for exactly one cycle, with hreadyout=1.
- Conflict (a read address phase in the same cycle as a write data phase): the write owns the port. Latch the read index.
  - Next cycle, state RSTALL: present the latched index with wen=0, hreadyout=0.
  - Following cycle, state READ: hreadyout=1, hrdata=ahb_dm_dout. Net cost is one wait state.
- Write followed by write: back-to-back, zero wait states.
- Read of an address written in the immediately preceding data phase returns the new data, via the stall path.
- ahb_dm_wen is never asserted in IDLE, READ, RSTALL, ERR1 or ERR2.
- hrdata holds its last value outside READ.
- While hreadyout=0, the bridge ignores new address phases; the master holds them.
- dm_access_en falling mid data phase: the transfer in flight completes as decoded. Subsequent transfers get ERROR.

Test Plan:
- Reset: rstn=0 with random AHB inputs -> hreadyout=1, hresp=0, ahb_dm_wen=0, ahb_dm_addr=0, hrdata=0.
- Write then read, non-adjacent: write 0xDEADBEEF to 0x0010, one IDLE cycle, then read 0x0010 -> ahb_dm_wen=1 for one cycle with ahb_dm_addr=4; read data phase has 0 waits and hrdata=0xDEADBEEF.
- Back-to-back write/read conflict: NONSEQ write 0x12345678 to 0x0020 immediately followed by a read of 0x0020 -> hreadyout low exactly 1 cycle (RSTALL), then hrdata=0x12345678.
- Burst: 4 SEQ writes to 0x0100..0x010C, then 4 SEQ reads -> writes 0 waits, first read 1 wait, remaining reads 0 waits, data matches.
- Errors: (a) hsize=000 write, (b) haddr=0x0002, (c) index=MEM_WORDS, (d) dm_access_en=0 -> each gives hreadyout 0 then 1 with hresp=1 both cycles, and ahb_dm_wen never asserted.
- Reset mid-stall: assert rstn low during RSTALL -> all outputs return to reset values immediately; a fresh read after release returns the correct SRAM content.
